// File: rtl/fetch_pkg.sv
// Shared fetch-path types: PC increment and the {pc, instr} queue entry layout.
package fetch_pkg;
  localparam int FETCH_BITS = 32;
  localparam int PC_STEP    = 4;

  typedef struct packed {
    logic [FETCH_BITS-1:0] pc;
    logic [FETCH_BITS-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO for fetched {pc, instr} pairs; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  entry_t        i_push_data,
  input  logic          i_pop,
  output entry_t        o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push, w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC holder and instruction-memory initiator feeding decode through a credit-limited queue.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int           BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter int           DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [BITS-1:0] mem_address,
  input  logic [BITS-1:0] mem_instruction,
  input  logic            redirect_valid,
  input  logic [BITS-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [BITS-1:0] instr_data,
  output logic [BITS-1:0] instr_pc,
  output logic            fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as fetch_entry_t, sized by this instance's BITS.
  typedef struct packed {
    logic [BITS-1:0] pc;
    logic [BITS-1:0] instr;
  } entry_t;

  logic [BITS-1:0] r_pc, r_inflight_pc, w_redir_pc;
  logic            r_inflight;
  logic            w_pop, w_issue, w_flush, w_fault, w_q_valid;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  entry_t          w_head, w_push_data;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;
  always_ff @(posedge clk) begin
    if (reset)               r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= |redirect_pc[1:0];
  end
  assign w_redir_pc = redirect_pc;
  assign w_fault    = r_fault;
`else
  assign w_redir_pc = redirect_pc & ~BITS'(3);
  assign w_fault    = 1'b0;
`endif

  assign w_pop   = w_q_valid && instr_ready;
  assign w_flush = reset || redirect_valid;
  // Credits: queued + in-flight, less what leaves this cycle, must leave room for the return.
  assign w_occ   = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = !reset && !redirect_valid && !w_fault && (w_occ < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redir_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + BITS'(PC_STEP);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  assign w_push_data = '{pc: r_inflight_pc, instr: mem_instruction};

  fetch_queue #(.DEPTH(DEPTH), .entry_t(entry_t)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_flush),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_q_valid),
    .o_count     (w_count)
  );

  assign mem_address = r_pc;
  assign instr_valid = w_q_valid;
  assign instr_data  = w_q_valid ? w_head.instr : '0;
  assign instr_pc    = w_q_valid ? w_head.pc    : '0;
  assign fetch_fault = w_fault;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed test-plan scenarios then random traffic against a queue-based fetch model.
module tb_instruction_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, instr_ready;
  logic [31:0] mem_address, mem_instruction, redirect_pc, instr_data, instr_pc;
  logic        instr_valid, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.BITS(32), .RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_000F;
      32'd4:   return 32'h0000_00FF;
      32'd8:   return 32'h0000_0FFF;
      default: return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Instruction memory: 1-cycle registered read.
  always @(posedge clk) mem_instruction <= memf(mem_address);

  typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_ipc;
  bit          m_infl, m_fault;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check current outputs, apply one cycle of inputs, advance model and clock.
  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit   pop, iss;
    int   occ;
    ent_t e;
    chk("valid", 64'(instr_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
      chk("instr_data", 64'(instr_data), 64'(mq[0].d));
    end
    chk("mem_address", 64'(mem_address), 64'(m_pc));
    chk("fault", 64'(fetch_fault), 64'(m_fault));
    reset = rst; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    pop = (mq.size() != 0) && rdy;
    if (rst) begin
      mq.delete(); m_pc = 32'd0; m_infl = 0; m_fault = 0;
    end else if (rv) begin
      mq.delete(); m_infl = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = rpc; m_fault = (rpc[1:0] != 2'b00);
`else
      m_pc = {rpc[31:2], 2'b00};
`endif
    end else begin
      occ = mq.size() + int'(m_infl) - int'(pop);
      iss = (occ < DEPTH) && !m_fault;
      if (pop) void'(mq.pop_front());
      if (m_infl) begin e.pc = m_ipc; e.d = memf(m_ipc); mq.push_back(e); end
      if (iss) begin m_ipc = m_pc; m_pc = m_pc + 32'd4; end
      m_infl = iss;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] d);
    chk({tag, "_v"}, 64'(instr_valid), 64'(1));
    chk({tag, "_pc"}, 64'(instr_pc), 64'(pc));
    chk({tag, "_d"}, 64'(instr_data), 64'(d));
  endtask

  initial begin
    bit          rst, rv, rdy;
    logic [31:0] rpc;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    m_pc = 32'd0; m_ipc = 32'd0; m_infl = 0; m_fault = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_addr", 64'(mem_address), 64'(0));
    chk("rst_data", 64'(instr_data), 64'(0));
    chk("rst_pc", 64'(instr_pc), 64'(0));
    chk("rst_fault", 64'(fetch_fault), 64'(0));

    // Streaming from reset with decode always ready.
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk_head("t1_a", 32'd0, 32'h0F); step(0, 0, 0, 1);
    chk_head("t1_b", 32'd4, 32'hFF); step(0, 0, 0, 1);
    chk_head("t1_c", 32'd8, 32'hFFF);

    // Backpressure: fetch stalls at 8 with the queue full and lossless.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t2_addr", 64'(mem_address), 64'(8));
    chk_head("t2_a", 32'd0, 32'h0F); step(0, 0, 0, 1);
    chk_head("t2_b", 32'd4, 32'hFF); step(0, 0, 0, 1);
    chk_head("t2_c", 32'd8, 32'hFFF);

    // Redirect to 8 while the read for 4 is in flight.
    step(1, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 32'd8, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk_head("t3", 32'd8, 32'hFFF);

    // Back-to-back redirects: last target wins.
    step(0, 1, 32'd4, 1); step(0, 1, 32'd0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk_head("t4", 32'd0, 32'h0F);

    // Reset with the queue full.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t5_valid", 64'(instr_valid), 64'(0));
    chk("t5_addr", 64'(mem_address), 64'(0));
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk_head("t5", 32'd0, 32'h0F);

`ifdef FETCH_MISALIGN_TRAP_EN
    step(0, 1, 32'd6, 1); step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk("t6_fault", 64'(fetch_fault), 64'(1));
    chk("t6_valid", 64'(instr_valid), 64'(0));
    step(0, 1, 32'd8, 1);
    chk("t6_clear", 64'(fetch_fault), 64'(0));
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk_head("t6", 32'd8, 32'hFFF);
`endif

    // Random traffic: resets, redirects (some misaligned, some near wrap), bursty ready.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      rv  = !rst && ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom();
        1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: rpc = 32'($urandom_range(0, 15) * 4);
      endcase
      rdy = ($urandom_range(0, 99) < 70);
      step(rst, rv, rpc, rdy);
    end
    step(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Holds the PC and issues word addresses to the instruction memory, which has a fixed 1-cycle registered read latency and no handshake.
- Captures returned words and presents {pc, instruction} to the decode stage through a valid/ready queue.
- Handles redirects (branch/jump) by flushing the queue and discarding the in-flight read.

Parameters:
- BITS, 32, address/instruction width.
- RESET_PC, 32'd0, PC value after reset.
- DEPTH, 2, fetch queue entries (power of 2, ≥2).

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- mem_address  output  BITS  word address presented to instruction memory.
- mem_instruction  input  BITS  memory read data, valid the cycle after the address was sampled.
- redirect_valid  input  1  load new PC this cycle.
- redirect_pc  input  BITS  redirect target.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode accepts head.
- instr_data  output  BITS  head instruction.
- instr_pc  output  BITS  head instruction's address.
- fetch_fault  output  1  misaligned redirect trap (optional feature only; tied 0 otherwise).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: pc=RESET_PC, mem_address=RESET_PC, inflight=0, queue count=0, instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0.
- mem_address is driven directly from the pc register.
- Issue condition: !reset && !redirect_valid && (count + inflight − pop) < DEPTH, where pop = instr_valid && instr_ready.
- On issue, at the edge: pc <= pc+4 (wraps modulo 2^BITS), inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Return: in any cycle with inflight=1, mem_instruction is pushed with inflight_pc at the clock edge. The credit rule guarantees the push never overflows; the memory cannot stall.
- Push and pop may occur in the same cycle. Count is unchanged; FIFO order is preserved.
- Queue contents are registered. There is no bypass: a word returned in cycle t appears at instr_valid in cycle t+1.
- Steady-state throughput: 1 instruction/cycle when instr_ready stays high.
- Redirect has priority over issue, push and pop. At the edge:
  - pc <= redirect_pc;
  - count <= 0;
  - inflight <= 0, so the current return is discarded;
  - any pop in that cycle is ignored.
- Redirect latency: redirect in cycle 0 → issue cycle 1 → return cycle 2 → instr_valid cycle 3.
- Back-to-back redirects: the last one wins. No instruction from an earlier target is ever delivered.
- Reset mid-operation: identical to a redirect to RESET_PC, and also clears fetch_fault.
- First instruction after reset deasserts (cycle 0) appears with instr_valid in cycle 2.
- instr_valid, once high, holds with stable instr_data/instr_pc until popped or redirected.
- X-valued mem_instruction (unmapped address) is passed through unmodified.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect_pc with bits [1:0] ≠ 0 sets fetch_fault (sticky until reset or the next aligned redirect). While fetch_fault is set, issue is blocked and the queue stays empty.
- Undefined: redirect_pc[1:0] is forced to 0 and fetch_fault is tied 0.

Decomposition:
- Package fetch_pkg:
  - constant PC_STEP=4;
  - typedef fetch_entry_t packed struct {pc, instr} of BITS each.
- Sub-module fetch_queue: a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush and count outputs.

Test Plan:
- Memory model holds 0x0000000F@0, 0x000000FF@4, 0x00000FFF@8; instr_ready=1 after reset. → instr_valid from cycle 2 with (pc,data) = (0,0x0000000F), (4,0x000000FF), (8,0x00000FFF) on consecutive cycles.
- instr_ready=0 for 5 cycles after reset. → mem_address stops advancing at 8; queue holds (0,0x0F),(4,0xFF) with no loss. On release, delivery continues with 8 (data 0x00000FFF).
- Redirect to 8 while pc=4 is in flight. → word for 4 is discarded; next delivered entry is (8,0x00000FFF), 3 cycles after redirect.
- Redirect to 4 and to 0 on consecutive cycles. → only (0,0x0000000F) is delivered first.
- Assert reset for 1 cycle mid-stream with queue full. → next cycle instr_valid=0 and mem_address=0; (0,0x0000000F) reappears 2 cycles after reset deasserts.
- With FETCH_MISALIGN_TRAP_EN, redirect to 6. → fetch_fault=1, no issue. A redirect to 8 clears the fault and delivers (8,0x00000FFF).
